// File: rtl/ram_cmd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ram_cmd_pkg : shared sizes, command codes and FSM states              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package ram_cmd_pkg;

  localparam int RAM_DEPTH = 16;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  // Opcode bits [7:6]
  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_DUMP  = 2'b10;
  localparam logic [1:0] CMD_BAD   = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WAIT_DATA  = 4'd1,
    ST_WRITE      = 4'd2,
    ST_RD_ADDR    = 4'd3,
    ST_RD_LATCH   = 4'd4,
    ST_DUMP_ADDR  = 4'd5,
    ST_DUMP_LATCH = 4'd6,
    ST_DUMP_SEND  = 4'd7,
    ST_SEND       = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_cmd_timeout.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ram_cmd_timeout : 32-bit gap counter, hit at TIMEOUT_CYCLES-1         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ram_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 27000000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic hit
);

  localparam logic [31:0] LAST_COUNT = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Saturates at the terminal value so a stale window never wraps round.
  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (!hit) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = (count_q == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/ram_cmd_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ram_cmd_ctrl : UART read/write/dump command sequencer for RAM16S      |
// | Build option RAM_CMD_TIMEOUT_EN adds the write-data timeout. Rev 1.0  |
// +-----------------------------------------------------------------------+
module ram_cmd_ctrl
  import ram_cmd_pkg::*;
#(
  parameter int unsigned        TIMEOUT_CYCLES = 27000000,
  parameter logic [DATA_W-1:0]  ACK_BYTE       = 8'h06,
  parameter logic [DATA_W-1:0]  NAK_BYTE       = 8'h15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_di,
  output logic              ram_wre,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              err_overrun
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [ADDR_W-1:0] ram_ad_q, ram_ad_d;
  logic [DATA_W-1:0] ram_di_q, ram_di_d;
  logic              ram_wre_q, ram_wre_d;
  logic              err_overrun_q, err_overrun_d;

  logic [1:0]        rx_cmd;
  logic [ADDR_W-1:0] rx_addr;
  logic              tx_accept;
  logic              timeout_hit;

  assign rx_cmd    = rx_data[7:6];
  assign rx_addr   = rx_data[ADDR_W-1:0];
  assign tx_accept = tx_valid_q & tx_ready;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_WAIT_DATA);

`ifdef RAM_CMD_TIMEOUT_EN
  logic timeout_start;
  assign timeout_start = (state_q == ST_IDLE) && rx_valid && (rx_cmd == CMD_WRITE);

  ram_cmd_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .start (timeout_start),
    .hit   (timeout_hit)
  );
`else
  // No timer in this build; the parameter stays referenced but has no effect.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    ram_ad_d      = ram_ad_q;
    ram_di_d      = ram_di_q;
    ram_wre_d     = 1'b0;
    err_overrun_d = err_overrun_q | (rx_valid & busy);

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_cmd)
            CMD_READ: begin
              ram_ad_d = rx_addr;
              state_d  = ST_RD_ADDR;
            end
            CMD_WRITE: begin
              ram_ad_d = rx_addr;
              state_d  = ST_WAIT_DATA;
            end
            CMD_DUMP: begin
              ram_ad_d = '0;
              state_d  = ST_DUMP_ADDR;
            end
            CMD_BAD: begin
              tx_data_d  = NAK_BYTE;
              tx_valid_d = 1'b1;
              state_d    = ST_SEND;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_WAIT_DATA: begin
        // Data arriving in the terminal timeout cycle still wins.
        if (rx_valid) begin
          ram_di_d  = rx_data;
          ram_wre_d = 1'b1;
          state_d   = ST_WRITE;
        end else if (timeout_hit) begin
          tx_data_d  = NAK_BYTE;
          tx_valid_d = 1'b1;
          state_d    = ST_SEND;
        end
      end
      ST_WRITE: begin
        tx_data_d  = ACK_BYTE;
        tx_valid_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_RD_ADDR:  state_d = ST_RD_LATCH;
      ST_RD_LATCH: begin
        tx_data_d  = ram_dout;
        tx_valid_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_DUMP_ADDR:  state_d = ST_DUMP_LATCH;
      ST_DUMP_LATCH: begin
        tx_data_d  = ram_dout;
        tx_valid_d = 1'b1;
        state_d    = ST_DUMP_SEND;
      end
      ST_DUMP_SEND: begin
        // Terminal test before incrementing keeps the dump at 16 bytes.
        if (tx_accept) begin
          tx_valid_d = 1'b0;
          if (ram_ad_q == LAST_ADDR) begin
            state_d = ST_IDLE;
          end else begin
            ram_ad_d = ram_ad_q + ADDR_W'(1);
            state_d  = ST_DUMP_ADDR;
          end
        end
      end
      ST_SEND: begin
        if (tx_accept) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      ram_ad_q      <= '0;
      ram_di_q      <= '0;
      ram_wre_q     <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      ram_ad_q      <= ram_ad_d;
      ram_di_q      <= ram_di_d;
      ram_wre_q     <= ram_wre_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign ram_ad      = ram_ad_q;
  assign ram_di      = ram_di_q;
  assign ram_wre     = ram_wre_q;
  assign err_overrun = err_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_cmd_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ram_cmd_ctrl : randomized command bench with a host-level model    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_ram_cmd_ctrl;

  localparam int          TO  = 100;
  localparam logic [7:0]  ACK = 8'h06;
  localparam logic [7:0]  NAK = 8'h15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [3:0] ram_ad;
  logic [7:0] ram_di;
  logic       ram_wre;
  logic [7:0] ram_dout = 8'h00;
  logic       busy;
  logic       err_overrun;

  ram_cmd_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .ACK_BYTE       (ACK),
    .NAK_BYTE       (NAK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ram_ad      (ram_ad),
    .ram_di      (ram_di),
    .ram_wre     (ram_wre),
    .ram_dout    (ram_dout),
    .busy        (busy),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM16S stand-in
  logic [7:0] ram [16] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_wre) ram[ram_ad] <= ram_di;
    ram_dout <= ram[ram_ad];
  end

  // 0 = hold low, 1 = hold high, otherwise random
  int rdy_mode = 2;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      tx_ready = 1'b0;
    else if (rdy_mode == 1) tx_ready = 1'b1;
    else                    tx_ready = ($urandom_range(0, 2) != 0);
  end

  // Host-level reference model
  logic [7:0]  mem [16] = '{default: 8'h00};
  bit          waiting = 1'b0;
  logic [3:0]  wr_addr = 4'h0;
  logic [7:0]  exp_tx [$];
  logic [11:0] exp_wr [$];
  bit          exp_overrun = 1'b0;
  logic [7:0]  acc_log [$];
  int          n_wre = 0;
  int          last_acc = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_apply(input logic [7:0] b);
    if (waiting) begin
      mem[wr_addr] = b;
      exp_wr.push_back({wr_addr, b});
      exp_tx.push_back(ACK);
      waiting = 1'b0;
    end else begin
      case (b[7:6])
        2'b00: exp_tx.push_back(mem[b[3:0]]);
        2'b01: begin waiting = 1'b1; wr_addr = b[3:0]; end
        2'b10: for (int i = 0; i < 16; i++) exp_tx.push_back(mem[i]);
        default: exp_tx.push_back(NAK);
      endcase
    end
  endtask

  task automatic model_reset();
    exp_tx.delete();
    exp_wr.delete();
    waiting     = 1'b0;
    exp_overrun = 1'b0;
  endtask

  // Called just after a posedge+1; returns at the next posedge+1.
  task automatic send_byte(input logic [7:0] b, output int e_no);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    e_no     = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (exp_tx.size() == 0 && !busy && !tx_valid) break;
      @(posedge clk); #1;
    end
    check("cmd_complete_in_budget", (k < budget), 1);
  endtask

  task automatic host_cmd(input logic [7:0] b);
    int e;
    send_byte(b, e);
    model_apply(b);
    wait_done(400);
  endtask

  task automatic inject_overrun(input logic [7:0] junk);
    int e;
    if (busy) begin
      send_byte(junk, e);
      exp_overrun = 1'b1;
    end
  endtask

  task automatic read_timed(input logic [3:0] a, input string tag);
    logic [7:0] want;
    int e;
    want = mem[a];
    send_byte({4'b0000, a}, e);
    model_apply({4'b0000, a});
    @(posedge clk); #1;
    check({tag, "_lat1_no_valid"}, tx_valid, 0);
    @(posedge clk); #1;
    check({tag, "_lat2_valid_data"}, {tx_valid, tx_data}, {1'b1, want});
    wait_done(100);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_ram_wre"}, ram_wre, 0);
    check({tag, "_ram_ad"}, ram_ad, 0);
    check({tag, "_ram_di"}, ram_di, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_overrun"}, err_overrun, 0);
  endtask

  function automatic logic [8:0] log_at(input int i);
    return (i < acc_log.size()) ? {1'b0, acc_log[i]} : 9'h100;
  endfunction

  // Compare process: every cycle, sampled on the falling edge
  bit         prev_valid = 1'b0;
  bit         prev_acc = 1'b0;
  bit         prev_wre = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      check("in_reset_tx_valid", tx_valid, 0);
      check("in_reset_ram_wre", ram_wre, 0);
      check("in_reset_err_overrun", err_overrun, 0);
      prev_valid = 1'b0;
      prev_acc   = 1'b0;
      prev_wre   = 1'b0;
    end else begin
      check("err_overrun_flag", err_overrun, exp_overrun);
      if (prev_valid && !prev_acc)
        check("tx_held_until_accept", {tx_valid, tx_data}, {1'b1, prev_data});
      if (ram_wre) begin
        n_wre++;
        check("ram_wre_single_cycle", prev_wre, 0);
        check("ram_write_expected", (exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) check("ram_write_addr_data", {ram_ad, ram_di}, exp_wr.pop_front());
      end
      if (tx_valid && tx_ready) begin
        acc_log.push_back(tx_data);
        last_acc = cyc + 1;
        check("tx_byte_expected", (exp_tx.size() != 0), 1);
        if (exp_tx.size() != 0) check("tx_byte_value", tx_data, exp_tx.pop_front());
      end
      prev_valid = tx_valid;
      prev_acc   = tx_valid && tx_ready;
      prev_data  = tx_data;
      prev_wre   = ram_wre;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, t, w0;
    bit found;
    int sel;
    logic [3:0] a;
    logic [1:0] hi;
    logic [7:0] junk;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Write 0xA5 to address 3, then read it back with exact latency
    w0 = n_wre;
    acc_log.delete();
    host_cmd(8'h43);
    host_cmd(8'hA5);
    check("t1_one_write_pulse", n_wre - w0, 1);
    read_timed(4'h3, "t1_read");
    check("t1_log_size", acc_log.size(), 2);
    check("t1_ack_byte", log_at(0), 9'h006);
    check("t1_read_byte", log_at(1), 9'h0A5);

    // Fill mem[i] = i ^ 5A, then dump with random ready and an overrun
    for (int i = 0; i < 16; i++) begin
      host_cmd({4'b0100, 4'(i)});
      host_cmd(8'(i) ^ 8'h5A);
    end
    acc_log.delete();
    rdy_mode = 2;
    send_byte(8'h80, e);
    model_apply(8'h80);
    repeat (5) @(posedge clk);
    #1;
    check("t2_busy_during_dump", busy, 1);
    inject_overrun(8'h03);
    check("t2_err_overrun_set", err_overrun, 1);
    wait_done(400);
    repeat (10) @(posedge clk);
    #1;
    check("t2_dump_16_bytes", acc_log.size(), 16);
    check("t2_dump_byte0", log_at(0), 9'h05A);
    check("t2_dump_byte1", log_at(1), 9'h05B);
    check("t2_dump_byte2", log_at(2), 9'h058);
    check("t2_dump_byte15", log_at(15), 9'h055);
    check("t2_no_17th_valid", tx_valid, 0);

    // Dump with ready held high: 48 clocks opcode to last acceptance
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'hB7, e);
    model_apply(8'hB7);
    wait_done(200);
    check("t2_dump_48_clocks", last_acc - e, 48);

    // Illegal opcode
    rdy_mode = 2;
    w0 = n_wre;
    acc_log.delete();
    host_cmd(8'hC7);
    check("t3_nak_count", acc_log.size(), 1);
    check("t3_nak_byte", log_at(0), 9'h015);
    check("t3_no_write", n_wre - w0, 0);

    // Write opcode with no data byte
    acc_log.delete();
    w0 = n_wre;
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h41, e);
    model_apply(8'h41);
`ifdef RAM_CMD_TIMEOUT_EN
    exp_tx.push_back(NAK);
    waiting = 1'b0;
    found = 1'b0;
    t = 0;
    for (int k = 0; k < 2 * TO && !found; k++) begin
      @(posedge clk); #1;
      if (tx_valid) begin found = 1'b1; t = cyc; end
    end
    check("t4_timeout_nak_seen", found, 1);
    check("t4_timeout_latency", t - e, TO);
    wait_done(20);
    check("t4_back_idle", busy, 0);
    check("t4_nak_byte", log_at(0), 9'h015);
    check("t4_no_write", n_wre - w0, 0);
    read_timed(4'h1, "t4_read_after_timeout");
`else
    repeat (TO + 50) @(posedge clk);
    #1;
    check("t4_still_waiting_no_tx", tx_valid, 0);
    check("t4_still_waiting_not_busy", busy, 0);
    check("t4_no_write_yet", n_wre - w0, 0);
    host_cmd(8'h3C);
    check("t4_late_data_written", n_wre - w0, 1);
    check("t4_late_ack", log_at(0), 9'h006);
`endif

    // Randomized command mix
    rdy_mode = 2;
    for (int n = 0; n < 80; n++) begin
      sel  = int'($urandom_range(0, 9));
      a    = 4'($urandom_range(0, 15));
      hi   = 2'($urandom_range(0, 3));
      junk = 8'($urandom);
      case (sel)
        0, 1, 2, 3: host_cmd({2'b00, hi, a});
        4, 5, 6: begin
          host_cmd({2'b01, hi, a});
          host_cmd(junk);
        end
        7: host_cmd({2'b10, hi, a});
        8: host_cmd({2'b11, hi, a});
        default: begin
          send_byte({2'b00, hi, a}, e);
          model_apply({2'b00, hi, a});
          inject_overrun(junk);
          wait_done(400);
        end
      endcase
    end

    // Reset while a byte is pending and the UART is stalled
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h05, e);
    model_apply(8'h05);
    repeat (4) @(posedge clk);
    #1;
    check("t6_pending_before_reset", tx_valid, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 2;
    @(posedge clk); #1;
    read_timed(4'h5, "t6_read_after_reset");

    check("final_tx_queue_empty", exp_tx.size(), 0);
    check("final_write_queue_empty", exp_wr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
